// File: rtl/decoder_sel_sequencer_pkg.sv
// Shared constants and types for the decoder select sequencer.
//   MODE_*  : run modes presented on the mode input
//   DIR_*   : direction encoding of the internal ping-pong direction flag
package decoder_sel_sequencer_pkg;
  typedef logic [1:0] mode_t;
  typedef logic [3:0] sel_t;

  localparam mode_t MODE_UP   = 2'b00;
  localparam mode_t MODE_DN   = 2'b01;
  localparam mode_t MODE_PP   = 2'b10;
  localparam mode_t MODE_HOLD = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam sel_t SEL_MAX = 4'd15;
  localparam sel_t SEL_MIN = 4'd0;
endpackage

// File: rtl/decoder_sel_sequencer_if.sv
// Control/observation bundle of the select sequencer.
//   master : drives en, mode, load, load_val; observes sel, A..D, step, wrap
//   slave  : the sequencer side
interface decoder_sel_sequencer_if;
  import decoder_sel_sequencer_pkg::*;
  logic  en;
  mode_t mode;
  logic  load;
  sel_t  load_val;
  sel_t  sel;
  logic  A, B, C, D;
  logic  step;
  logic  wrap;

  modport master (output en, mode, load, load_val,
                  input  sel, A, B, C, D, step, wrap);
  modport slave  (input  en, mode, load, load_val,
                  output sel, A, B, C, D, step, wrap);
endinterface

// File: rtl/decoder_sel_sequencer_tick_prescaler.sv
// tick_prescaler: counts enabled cycles and raises tick on the last one of
// every TICK_DIV-cycle period.
//   clk, rst : clock, async active-high reset
//   en       : advance the count; en=0 freezes it in place
//   clr      : synchronous return to 0, overrides en
//   tick     : combinational, high while en=1 and the count is at TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 5,
  parameter int DIV_W    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/decoder_sel_sequencer.sv
// decoder_sel_sequencer: produces the 4-bit select code (A=LSB .. D=MSB) for
// the 4-to-16 decoder, stepping it up/down/ping-pong/hold at a prescaled rate.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of decoder_sel_sequencer_if
//              en/mode/load/load_val in; sel, A..D, step, wrap out
// step marks the cycle a freshly stepped sel is presented; wrap marks the
// 15<->0 wrap or a ping-pong turnaround in that same cycle.
module decoder_sel_sequencer
  import decoder_sel_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 5,
  parameter int DIV_W    = 3
) (
  input logic                     clk,
  input logic                     rst,
  decoder_sel_sequencer_if.slave  bus
);
  logic tick;
  sel_t sel_q, sel_d;
  logic dir_q, dir_d;
  logic step_q, step_d;
  logic wrap_q, wrap_d;

  tick_prescaler #(.TICK_DIV(TICK_DIV), .DIV_W(DIV_W)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (bus.en),
    .clr  (bus.load),
    .tick (tick)
  );

  always_comb begin
    sel_d  = sel_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (bus.load) begin
      // load beats a coincident tick; that tick is simply lost
      sel_d = bus.load_val;
    end else if (tick) begin
      unique case (bus.mode)
        MODE_UP: begin
          dir_d  = DIR_UP;
          step_d = 1'b1;
          wrap_d = (sel_q == SEL_MAX);
          sel_d  = sel_q + 4'd1;
        end
        MODE_DN: begin
          dir_d  = DIR_DN;
          step_d = 1'b1;
          wrap_d = (sel_q == SEL_MIN);
          sel_d  = sel_q - 4'd1;
        end
        MODE_PP: begin
          step_d = 1'b1;
          // turn around at the ends instead of wrapping, so no value repeats
          if (dir_q == DIR_UP) begin
            if (sel_q == SEL_MAX) begin
              sel_d  = SEL_MAX - 4'd1;
              dir_d  = DIR_DN;
              wrap_d = 1'b1;
            end else begin
              sel_d = sel_q + 4'd1;
            end
          end else begin
            if (sel_q == SEL_MIN) begin
              sel_d  = SEL_MIN + 4'd1;
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end else begin
              sel_d = sel_q - 4'd1;
            end
          end
        end
        default: ; // hold: prescaler keeps running, sel and dir stay put
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q  <= SEL_MIN;
      dir_q  <= DIR_UP;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.sel  = sel_q;
  assign bus.A    = sel_q[0];
  assign bus.B    = sel_q[1];
  assign bus.C    = sel_q[2];
  assign bus.D    = sel_q[3];
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;
endmodule
